// File: rtl/memory_game_pkg.sv
// memory_game_pkg: shared card status encodings, controller states and game defaults
package memory_game_pkg;
    localparam int DEF_N_CARDS = 16;
    localparam int DEF_HIDE_DELAY = 32500000;
    localparam logic [1:0] ST_HIDDEN = 2'd0;
    localparam logic [1:0] ST_SHOWN = 2'd1;
    localparam logic [1:0] ST_MATCHED = 2'd2;
    typedef enum logic [3:0] {
        IDLE, WAIT1, READ1, CHK1, REVEAL1, WAIT2, READ2, CHK2, REVEAL2,
        COMPARE, HOLD, RESOLVE_A, RESOLVE_B, DONE
    } state_t;
endpackage

// File: rtl/hold_timer.sv
// hold_timer: loadable down-counter that flags done when it reaches zero
module hold_timer #(
    parameter int W = 25
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (!done) cnt <= cnt - W'(1);
    end
    assign done = cnt == '0;
endmodule

// File: rtl/pair_controller.sv
// pair_controller: sequences one memory-game turn between click decoder and card-state RAM
module pair_controller import memory_game_pkg::*; #(
    parameter int N_CARDS = DEF_N_CARDS,
    parameter int IDX_W = 4,
    parameter int COLOR_W = 3,
    parameter int HIDE_DELAY = DEF_HIDE_DELAY
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               click_valid,
    input  logic [IDX_W-1:0]   click_idx,
    output logic [IDX_W-1:0]   rd_addr,
    input  logic [COLOR_W-1:0] rd_color,
    input  logic [1:0]         rd_status,
    output logic               wr_en,
    output logic [IDX_W-1:0]   wr_addr,
    output logic [1:0]         wr_status,
    output logic               redraw,
    output logic               busy,
    output logic               game_over,
    output logic [IDX_W-1:0]   pairs,
    output logic [7:0]         moves
);
    localparam int TW = $clog2(HIDE_DELAY + 1);
    localparam logic [IDX_W:0] CARD_LIM = (IDX_W+1)'(N_CARDS);
    localparam logic [IDX_W-1:0] PAIR_LIM = IDX_W'(N_CARDS / 2);

    state_t state, state_n;
    logic [IDX_W-1:0] idx1, idx2, wr_idx;
    logic [COLOR_W-1:0] color1, color2;
    logic [1:0] res_st, wr_st;
    logic click_ok, wr_go, fin, rdp, load, t_done, same;

    // the RAM is addressed straight from the accepted click so its data is ready in CHKx
    assign click_ok = click_valid && ({1'b0, click_idx} < CARD_LIM) && !redraw;
    assign same = color1 == color2;

    hold_timer #(.W(TW)) u_timer (
        .clk(clk), .rst(rst), .load(load), .load_val(TW'(HIDE_DELAY - 1)), .done(t_done)
    );

    always_comb begin
        state_n = state;
        wr_go = 1'b0;
        wr_idx = idx1;
        wr_st = ST_SHOWN;
        fin = 1'b0;
        load = 1'b0;
        case (state)
            IDLE, DONE: state_n = start ? WAIT1 : state;
            WAIT1:      state_n = click_ok ? READ1 : WAIT1;
            READ1:      state_n = CHK1;
            CHK1:       state_n = rd_status == ST_HIDDEN ? REVEAL1 : WAIT1;
            REVEAL1:    begin wr_go = 1'b1; fin = 1'b1; state_n = WAIT2; end
            WAIT2:      state_n = click_ok ? READ2 : WAIT2;
            READ2:      state_n = CHK2;
            CHK2:       state_n = rd_status == ST_HIDDEN ? REVEAL2 : WAIT2;
            REVEAL2:    begin wr_go = 1'b1; wr_idx = idx2; fin = 1'b1; state_n = COMPARE; end
            COMPARE:    begin load = !same; state_n = same ? RESOLVE_A : HOLD; end
            HOLD:       state_n = t_done ? RESOLVE_A : HOLD;
            RESOLVE_A:  begin wr_go = 1'b1; wr_st = res_st; state_n = RESOLVE_B; end
            RESOLVE_B:  begin
                wr_go = 1'b1; wr_idx = idx2; wr_st = res_st; fin = 1'b1;
                state_n = pairs == PAIR_LIM ? DONE : WAIT1;
            end
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rd_addr <= '0;
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_status <= ST_HIDDEN;
            redraw <= 1'b0;
            rdp <= 1'b0;
            busy <= 1'b0;
            game_over <= 1'b0;
            pairs <= '0;
            moves <= '0;
            idx1 <= '0;
            idx2 <= '0;
            color1 <= '0;
            color2 <= '0;
            res_st <= ST_HIDDEN;
        end else begin
            state <= state_n;
            wr_en <= wr_go;
            rdp <= fin;
            redraw <= rdp;
            busy <= !(state_n inside {IDLE, WAIT1, WAIT2, DONE});
            // game_over waits until the final redraw has gone out
            game_over <= state_n == DONE && !fin && !rdp;
            if (wr_go) begin
                wr_addr <= wr_idx;
                wr_status <= wr_st;
            end
            if ((state == WAIT1 || state == WAIT2) && click_ok) rd_addr <= click_idx;
            if (state == WAIT1 && click_ok) idx1 <= click_idx;
            if (state == WAIT2 && click_ok) idx2 <= click_idx;
            if (state == CHK1) color1 <= rd_color;
            if (state == CHK2) color2 <= rd_color;
            if (state == COMPARE) begin
                moves <= moves == 8'hFF ? moves : moves + 8'd1;
                pairs <= same ? pairs + IDX_W'(1) : pairs;
                res_st <= same ? ST_MATCHED : ST_HIDDEN;
            end
            if ((state == IDLE || state == DONE) && start) begin
                pairs <= '0;
                moves <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pair_controller.sv
// tb_pair_controller: directed turns against a 1-cycle-latency card RAM model
module tb_pair_controller;
    import memory_game_pkg::*;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, click_valid = 1'b0, ram_init = 1'b1;
    logic [4:0] click_idx = '0, rd_addr, wr_addr, pairs;
    logic [2:0] rd_color;
    logic [1:0] rd_status, wr_status;
    logic wr_en, redraw, busy, game_over;
    logic [7:0] moves;

    logic [1:0] st_mem [32];
    logic [2:0] col_mem [32];
    int cyc = 0, hold_cyc = 0, overlap = 0, n_checks = 0, n_err = 0;
    int wq_c[$], wq_a[$], wq_s[$], rq[$];

    pair_controller #(.N_CARDS(16), .IDX_W(5), .COLOR_W(3), .HIDE_DELAY(4)) dut (
        .clk(clk), .rst(rst), .start(start), .click_valid(click_valid), .click_idx(click_idx),
        .rd_addr(rd_addr), .rd_color(rd_color), .rd_status(rd_status), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_status(wr_status), .redraw(redraw), .busy(busy),
        .game_over(game_over), .pairs(pairs), .moves(moves)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_status <= st_mem[rd_addr];
        rd_color <= col_mem[rd_addr];
        if (ram_init) for (int i = 0; i < 32; i++) st_mem[i] <= ST_HIDDEN;
        else if (wr_en) st_mem[wr_addr] <= wr_status;
    end

    always @(negedge clk) begin
        if (wr_en) begin
            wq_c.push_back(cyc);
            wq_a.push_back(int'(wr_addr));
            wq_s.push_back(int'(wr_status));
        end
        if (redraw) rq.push_back(cyc);
        if (dut.state == HOLD) hold_cyc++;
        if (wr_en && redraw) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_wr(input string tag, input int k, input int c, input int a, input int s);
        if (wq_c.size() > k) begin
            check({tag, "_cyc"}, wq_c[k], c);
            check({tag, "_addr"}, wq_a[k], a);
            check({tag, "_st"}, wq_s[k], s);
        end else check({tag, "_missing"}, wq_c.size(), k + 1);
    endtask

    task automatic check_rd(input string tag, input int k, input int c);
        if (rq.size() > k) check(tag, rq[k], c);
        else check({tag, "_missing"}, rq.size(), k + 1);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic click(input int idx, output int c);
        @(negedge clk);
        click_valid = 1'b1;
        click_idx = 5'(idx);
        @(negedge clk);
        click_valid = 1'b0;
        c = cyc;
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic play(input int a, input int b, output int cb);
        int ca;
        click(a, ca);
        wait_cyc(5);
        click(b, cb);
    endtask

    initial begin
        int c, c2, wb, rb, hb;
        for (int i = 0; i < 32; i++) col_mem[i] = 3'(i >> 1);
        col_mem[2] = 3'd1; col_mem[6] = 3'd1;
        col_mem[3] = 3'd2; col_mem[7] = 3'd2;
        col_mem[4] = 3'd3; col_mem[5] = 3'd3;
        wait_cyc(3);
        rst = 1'b0;
        ram_init = 1'b0;
        check("rst_wr_en", wr_en, 0);
        check("rst_redraw", redraw, 0);
        check("rst_game_over", game_over, 0);
        check("rst_busy", busy, 0);
        check("rst_addrs", {rd_addr, wr_addr, wr_status}, 0);
        check("rst_counts", {pairs, moves}, 0);
        check("rst_state", dut.state, IDLE);

        pulse_start;
        check("start_state", dut.state, WAIT1);

        wb = wq_c.size(); rb = rq.size();
        click(3, c);
        wait_cyc(5);
        check("rev1_nwr", wq_c.size() - wb, 1);
        check_wr("rev1", wb, c + 3, 3, ST_SHOWN);
        check_rd("rev1_redraw", rb, c + 4);
        check("rev1_state", dut.state, WAIT2);
        check("rev1_busy", busy, 0);

        wb = wq_c.size();
        click(3, c);
        wait_cyc(6);
        check("reclick_nwr", wq_c.size() - wb, 0);
        check("reclick_state", dut.state, WAIT2);
        click(16, c);
        wait_cyc(6);
        check("oor_nwr", wq_c.size() - wb, 0);
        check("oor_state", dut.state, WAIT2);

        wb = wq_c.size(); rb = rq.size(); hb = hold_cyc;
        click(5, c);
        wait_cyc(4);
        click(7, c2);
        wait_cyc(8);
        check("mis_nwr", wq_c.size() - wb, 3);
        check_wr("mis_rev2", wb, c + 3, 5, ST_SHOWN);
        check_wr("mis_hide_a", wb + 1, c + 9, 3, ST_HIDDEN);
        check_wr("mis_hide_b", wb + 2, c + 10, 5, ST_HIDDEN);
        check_rd("mis_redraw", rb + 1, c + 11);
        check("mis_hold_cycles", hold_cyc - hb, 4);
        check("mis_moves", moves, 1);
        check("mis_pairs", pairs, 0);
        check("mis_state", dut.state, WAIT1);

        wb = wq_c.size(); rb = rq.size(); hb = hold_cyc;
        play(3, 7, c);
        wait_cyc(8);
        check("match_nwr", wq_c.size() - wb, 4);
        check_wr("match_a", wb + 2, c + 5, 3, ST_MATCHED);
        check_wr("match_b", wb + 3, c + 6, 7, ST_MATCHED);
        check_rd("match_redraw", rb + 2, c + 7);
        check("match_no_hold", hold_cyc - hb, 0);
        check("match_pairs", pairs, 1);
        check("match_moves", moves, 2);

        wb = wq_c.size();
        play(0, 3, c);
        wait_cyc(6);
        check("matched_click_nwr", wq_c.size() - wb, 1);
        check("matched_click_state", dut.state, WAIT2);
        click(1, c);
        wait_cyc(8);
        check("pair01_pairs", pairs, 2);

        play(2, 6, c); wait_cyc(8);
        play(4, 5, c); wait_cyc(8);
        play(8, 9, c); wait_cyc(8);
        play(10, 11, c); wait_cyc(8);
        play(12, 13, c); wait_cyc(8);
        play(14, 15, c);
        wait_cyc(7);
        check("final_redraw", redraw, 1);
        check("final_go_early", game_over, 0);
        wait_cyc(1);
        check("final_game_over", game_over, 1);
        check("final_pairs", pairs, 8);
        check("final_moves", moves, 9);
        check("final_busy", busy, 0);

        pulse_start;
        check("restart_counts", {pairs, moves}, 0);
        check("restart_game_over", game_over, 0);
        check("restart_state", dut.state, WAIT1);

        @(negedge clk); ram_init = 1'b1;
        @(negedge clk); ram_init = 1'b0;
        wb = wq_c.size();
        play(3, 5, c);
        wait_cyc(6);
        check("rst_hold_state", dut.state, HOLD);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        wait_cyc(8);
        check("rst_hold_nwr", wq_c.size() - wb, 2);
        check("rst_hold_idle", dut.state, IDLE);
        check("rst_hold_outs", {wr_en, redraw, busy, game_over}, 0);

        check("wr_redraw_overlap", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
